instruction_fetch_queue: RTL and testbench

Next-generation IF stage: PC generator, instruction memory, UART program loader and a parametrised prefetch queue in one block. It fetches ahead of the decoder into a DEPTH-entry FIFO and hands instructions to if_id_reg with a valid/ready handshake. Redirects from the branch unit flush the queue and any in-flight read. Sits between hazard_unit/uart_unit and if_id_reg.

---
 rtl/instruction_fetch_queue.sv | 177 +++++++++++++++++
 tb/tb_instruction_fetch_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// ----------------------------------------------------------------------------
// instruction_fetch_queue : PC generator, UART-loadable instruction memory and
// prefetch FIFO. Optional macro IF_PERF_COUNTER_EN builds the perf counters.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_queue #(
  parameter int                  ISA_WIDTH   = 32,
  parameter int                  ROM_DEPTH   = 14,
  parameter int                  QUEUE_DEPTH = 4,
  parameter logic [ISA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_disable,
  input  logic                 uart_write_enable,
  input  logic [ROM_DEPTH:0]   uart_addr,
  input  logic [ISA_WIDTH-1:0] uart_data,
  input  logic                 pc_reset,
  input  logic                 redirect_valid,
  input  logic [ISA_WIDTH-1:0] redirect_pc,
  input  logic                 inst_ready,
  output logic                 inst_valid,
  output logic [ISA_WIDTH-1:0] inst_data,
  output logic [ISA_WIDTH-1:0] inst_pc,
  output logic [ISA_WIDTH-1:0] fetch_pc,
  output logic [31:0]          fetch_count,
  output logic [31:0]          flush_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W+1)'(QUEUE_DEPTH);

  logic [ISA_WIDTH-1:0] mem [0:(1<<ROM_DEPTH)-1];
  logic [ISA_WIDTH-1:0] rdata_q;

  logic [ISA_WIDTH-1:0] qdata_q [QUEUE_DEPTH];
  logic [ISA_WIDTH-1:0] qpc_q   [QUEUE_DEPTH];
  logic [PTR_W-1:0]     wptr_q, rptr_q;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 inflight_q;
  logic [ISA_WIDTH-1:0] inflight_pc_q;
  logic [ISA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                 halted_q;

  logic                 w_pop, w_push, w_issue;
  logic                 w_flush, w_flush_pcr, w_flush_redir;
  logic [CNT_W:0]       w_need;
  logic                 unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign inst_valid = (count_q != '0);
  assign inst_data  = qdata_q[rptr_q];
  assign inst_pc    = qpc_q[rptr_q];
  assign fetch_pc   = fetch_pc_q;

  // Once load mode has been entered, only pc_reset re-arms fetch; redirects are ignored meanwhile.
  assign w_flush_pcr   = uart_disable & pc_reset;
  assign w_flush_redir = uart_disable & ~pc_reset & ~halted_q & redirect_valid;
  assign w_flush       = ~uart_disable | w_flush_pcr | w_flush_redir;

  assign w_pop  = inst_valid & inst_ready;
  assign w_push = inflight_q & ~w_flush;

  assign w_need  = {1'b0, count_q} - {{CNT_W{1'b0}}, w_pop} + {{CNT_W{1'b0}}, inflight_q};
  assign w_issue = uart_disable & ~halted_q & ~w_flush & (w_need < C_DEPTH);

  always_comb begin
    count_d = count_q;
    if (w_flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop};
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (!uart_disable) begin
      fetch_pc_d = fetch_pc_q;
    end else if (pc_reset || halted_q) begin
      fetch_pc_d = RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ISA_WIDTH-1:2], 2'b00};
    end else if (w_issue) begin
      fetch_pc_d = fetch_pc_q + ISA_WIDTH'(4);
    end
  end

  // Memory has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (!uart_disable && uart_write_enable && !uart_addr[ROM_DEPTH]) begin
      mem[uart_addr[ROM_DEPTH-1:0]] <= uart_data;
    end
    if (w_issue) begin
      rdata_q <= mem[fetch_pc_q[ROM_DEPTH+1:2]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= w_issue;
      if (w_issue) begin
        inflight_pc_q <= fetch_pc_q;
      end
      if (!uart_disable) begin
        halted_q <= 1'b1;
      end else if (pc_reset) begin
        halted_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        qdata_q[i] <= '0;
        qpc_q[i]   <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (w_flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (w_push) begin
          qdata_q[wptr_q] <= rdata_q;
          qpc_q[wptr_q]   <= inflight_pc_q;
          wptr_q          <= wptr_q + 1'b1;
        end
        if (w_pop) begin
          rptr_q <= rptr_q + 1'b1;
        end
      end
    end
  end

`ifdef IF_PERF_COUNTER_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (w_pop) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (w_flush_pcr || w_flush_redir) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign fetch_count = 32'd0;
  assign flush_count = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_queue : directed self-checking bench for the fetch queue.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch_queue;

  localparam int ISA_WIDTH = 32;
  localparam int ROM_DEPTH = 14;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 uart_disable;
  logic                 uart_write_enable;
  logic [ROM_DEPTH:0]   uart_addr;
  logic [ISA_WIDTH-1:0] uart_data;
  logic                 pc_reset;
  logic                 redirect_valid;
  logic [ISA_WIDTH-1:0] redirect_pc;
  logic                 inst_ready;
  logic                 inst_valid;
  logic [ISA_WIDTH-1:0] inst_data;
  logic [ISA_WIDTH-1:0] inst_pc;
  logic [ISA_WIDTH-1:0] fetch_pc;
  logic [31:0]          fetch_count;
  logic [31:0]          flush_count;

  int checks = 0;
  int errors = 0;

  instruction_fetch_queue #(
    .ISA_WIDTH  (ISA_WIDTH),
    .ROM_DEPTH  (ROM_DEPTH),
    .QUEUE_DEPTH(4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .uart_disable     (uart_disable),
    .uart_write_enable(uart_write_enable),
    .uart_addr        (uart_addr),
    .uart_data        (uart_data),
    .pc_reset         (pc_reset),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_ready       (inst_ready),
    .inst_valid       (inst_valid),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .fetch_pc         (fetch_pc),
    .fetch_count      (fetch_count),
    .flush_count      (flush_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic ready);
    rst_n             = 1'b0;
    uart_disable      = 1'b1;
    uart_write_enable = 1'b0;
    pc_reset          = 1'b0;
    redirect_valid    = 1'b0;
    inst_ready        = ready;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic uart_write(input logic [ROM_DEPTH:0] a, input logic [31:0] d);
    uart_write_enable = 1'b1;
    uart_addr         = a;
    uart_data         = d;
    tick();
    uart_write_enable = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_word;

    rst_n = 1'b0; uart_disable = 1'b0; uart_write_enable = 1'b0;
    uart_addr = '0; uart_data = '0; pc_reset = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    #1;
    chk("reset_valid", inst_valid, 0);
    chk("reset_data", inst_data, 0);
    chk("reset_pc", inst_pc, 0);
    chk("reset_fetch_pc", fetch_pc, 0);
    chk("reset_fetch_count", fetch_count, 0);
    chk("reset_flush_count", flush_count, 0);
    #2 rst_n = 1'b1;

    // Load words 0..15 = 0x1000+i in load mode
    tick();
    for (int i = 0; i < 16; i++) uart_write(15'(i), 32'h1000 + i);
    chk("load_no_valid", inst_valid, 0);

    // Straight-line fetch after reset, ready held high
    do_reset(1'b1);
    tick();
    chk("lat_edge0_valid", inst_valid, 0);
    chk("lat_edge0_fetch_pc", fetch_pc, 4);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", inst_valid, 1);
      chk("stream_data", inst_data, 32'h1000 + i);
      chk("stream_pc", inst_pc, 4 * i);
      tick();
    end

    // Backpressure: queue fills to 4, issue stops at fetch_pc 16
    do_reset(1'b0);
    repeat (10) tick();
    chk("bp_valid", inst_valid, 1);
    chk("bp_data", inst_data, 32'h1000);
    chk("bp_pc", inst_pc, 0);
    chk("bp_fetch_pc", fetch_pc, 16);
    inst_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("bp_drain_valid", inst_valid, 1);
      chk("bp_drain_data", inst_data, 32'h1000 + i);
    end

    // Redirect with a full queue and a read in flight
    do_reset(1'b0);
    repeat (6) tick();
    inst_ready = 1'b1;
    tick();
    chk("pre_redir_data", inst_data, 32'h1001);
    chk("pre_redir_fetch_pc", fetch_pc, 20);
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h23;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid0", inst_valid, 0);
    chk("redir_fetch_pc", fetch_pc, 32'h20);
    tick();
    chk("redir_valid1", inst_valid, 0);
    tick();
    chk("redir_first_valid", inst_valid, 1);
    chk("redir_first_data", inst_data, 32'h1008);
    chk("redir_first_pc", inst_pc, 32'h20);
    inst_ready = 1'b1;
    tick();
    chk("redir_second_data", inst_data, 32'h1009);
    chk("redir_second_pc", inst_pc, 32'h24);

    // UART load mode: word 5 overwritten, data-region write ignored
    uart_disable = 1'b0;
    tick();
    chk("uart_flush_valid", inst_valid, 0);
    uart_write(15'd5, 32'hDEAD_BEEF);
    uart_write(15'h4005, 32'hBADB_AD00);
    uart_write(15'h3FFF, 32'hCAFE_F00D);
    uart_disable = 1'b1;
    tick();
    tick();
    chk("halted_valid", inst_valid, 0);
    chk("halted_fetch_pc", fetch_pc, 0);
    pc_reset = 1'b1;
    tick();
    pc_reset = 1'b0;
    chk("pcr_valid", inst_valid, 0);
    chk("pcr_fetch_pc", fetch_pc, 0);
    tick();
    chk("pcr_issue_valid", inst_valid, 0);
    chk("pcr_issue_fetch_pc", fetch_pc, 4);
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_word = (i == 5) ? 32'hDEAD_BEEF : 32'h1000 + i;
      chk("reload_valid", inst_valid, 1);
      chk("reload_data", inst_data, exp_word);
      chk("reload_pc", inst_pc, 4 * i);
      tick();
    end

    // Memory index wraps while the PC carries past 0xFFFC
    redirect_valid = 1'b1; redirect_pc = 32'hFFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_flush_valid", inst_valid, 0);
    chk("wrap_fetch_pc", fetch_pc, 32'hFFFC);
    tick();
    chk("wrap_fetch_pc_next", fetch_pc, 32'h1_0000);
    tick();
    chk("wrap_top_data", inst_data, 32'hCAFE_F00D);
    chk("wrap_top_pc", inst_pc, 32'hFFFC);
    tick();
    chk("wrap_zero_data", inst_data, 32'h1000);
    chk("wrap_zero_pc", inst_pc, 32'h1_0000);

    // Perf counters: 20 pops then 3 redirects from a fresh reset
    do_reset(1'b0);
    chk("cnt_reset_fetch", fetch_count, 0);
    chk("cnt_reset_flush", flush_count, 0);
    repeat (6) tick();
    inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("cnt_pop_valid", inst_valid, 1);
      tick();
    end
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
    end
`ifdef IF_PERF_COUNTER_EN
    chk("fetch_count", fetch_count, 20);
    chk("flush_count", flush_count, 3);
`else
    chk("fetch_count", fetch_count, 0);
    chk("flush_count", flush_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
